axis_prbs_checker: RTL

// - AXI-Stream sink for the decrypted data leaving the receiver FIFO (m_axis_fifo_rx_*).
// - Self-synchronises to a PRBS-31 word stream (x^31+x^28+1), then checks every beat.
// - Reports lock status plus saturating word, bit-error and sync-loss counters.
// - Closes the tx -> rx loopback for end-to-end ChaCha20 encrypt/decrypt checking.

---
 rtl/prbs_pkg.sv | 24 ++
 rtl/popcount32.sv | 16 +
 rtl/axis_prbs_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// PRBS-31 (x^31 + x^28 + 1) word generator shared by the stream checker.
package prbs_pkg;

    typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} prbs_state_t;

    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;

    // Returns {word[31:0], s_next[30:0]}; word[31] is the first generated bit.
    function automatic logic [62:0] prbs31_next(input logic [30:0] s);
        logic [30:0] st;
        logic [31:0] word;
        logic        b;
        st   = s;
        word = '0;
        for (int i = 31; i >= 0; i--) begin
            b       = st[PRBS31_TAP_A] ^ st[PRBS31_TAP_B];
            word[i] = b;
            st      = {st[29:0], b};
        end
        return {word, st};
    endfunction

endpackage

// File: rtl/popcount32.sv
// Counts the set bits of a 32-bit word.
// Latency: combinational.
// Backpressure: none.
module popcount32 (
    input  logic [31:0] din,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, din[i]};
        end
    end

endmodule

// File: rtl/axis_prbs_checker.sv
// AXI-Stream PRBS-31 sink: self-synchronises, then counts words, bit errors and sync losses.
// Latency: lock/word/sync-loss update 1 cycle after the beat, bit-error count 2 cycles.
// Backpressure: none; tready simply follows i_enable one cycle late.
module axis_prbs_checker
    import prbs_pkg::*;
#(
    parameter int C_LOCK_THRESHOLD = 4,
    parameter int C_LOSS_THRESHOLD = 8
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        i_enable,
    input  logic        i_clear,
    output logic        s_axis_tready,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    output logic        o_locked,
    output logic [31:0] o_word_count,
    output logic [31:0] o_bit_err_count,
    output logic [15:0] o_sync_loss_count
);

    prbs_state_t state;
    logic [30:0] lfsr;
    logic [3:0]  match_cnt;
    logic [7:0]  miss_cnt;

    logic        beat;
    logic [62:0] prbs_nxt;
    logic [31:0] exp_word;
    logic [30:0] exp_state;
    logic        hit;
    logic        seed_ok;
    logic        lock_evt;
    logic        loss_evt;
    logic        locked_beat;
    logic [31:0] err_bits;
    logic [5:0]  pop;
    logic [5:0]  pop_q;
    logic        pop_vld_q;
    logic [32:0] err_sum;

    assign beat        = s_axis_tvalid & s_axis_tready;
    assign prbs_nxt    = prbs31_next(lfsr);
    assign exp_word    = prbs_nxt[62:31];
    assign exp_state   = prbs_nxt[30:0];
    assign hit         = (s_axis_tdata == exp_word);
    assign seed_ok     = |s_axis_tdata[30:0];
    assign locked_beat = beat && (state == LOCKED);
    assign lock_evt    = beat && (state == VERIFY) && hit
                         && ((match_cnt + 4'd1) == 4'(C_LOCK_THRESHOLD));
    assign loss_evt    = locked_beat && !hit
                         && ((miss_cnt + 8'd1) == 8'(C_LOSS_THRESHOLD));
    assign err_bits    = exp_word ^ s_axis_tdata;
    assign err_sum     = {1'b0, o_bit_err_count} + {27'd0, pop_q};

    popcount32 u_popcount (
        .din (err_bits),
        .cnt (pop)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            lfsr          <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            o_locked      <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= i_enable;
            case (state)
                IDLE: begin
                    if (i_enable) state <= HUNT;
                end
                HUNT: begin
                    if (beat && seed_ok) begin
                        lfsr      <= s_axis_tdata[30:0];
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (beat) begin
                        if (hit) begin
                            lfsr      <= exp_state;
                            match_cnt <= match_cnt + 4'd1;
                            if (lock_evt) begin
                                state    <= LOCKED;
                                miss_cnt <= '0;
                                o_locked <= 1'b1;
                            end
                        end else if (seed_ok) begin
                            // A bad guess reseeds from the current beat rather than waiting.
                            lfsr      <= s_axis_tdata[30:0];
                            match_cnt <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        lfsr <= exp_state;
                        if (hit) begin
                            miss_cnt <= '0;
                        end else if (loss_evt) begin
                            state    <= HUNT;
                            o_locked <= 1'b0;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Disable overrides whatever the beat decided, after the beat is consumed.
            if (!i_enable) begin
                state    <= IDLE;
                o_locked <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            pop_q             <= '0;
            pop_vld_q         <= 1'b0;
            o_word_count      <= '0;
            o_bit_err_count   <= '0;
            o_sync_loss_count <= '0;
        end else begin
            pop_q     <= pop;
            pop_vld_q <= locked_beat && !i_clear;
            if (i_clear) begin
                o_word_count      <= '0;
                o_bit_err_count   <= '0;
                o_sync_loss_count <= '0;
            end else begin
                if (locked_beat && (o_word_count != '1))
                    o_word_count <= o_word_count + 32'd1;
                if (loss_evt && (o_sync_loss_count != '1))
                    o_sync_loss_count <= o_sync_loss_count + 16'd1;
                if (pop_vld_q)
                    o_bit_err_count <= err_sum[32] ? '1 : err_sum[31:0];
            end
        end
    end

endmodule
